// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32 control units: opcodes, ALU/immediate codes,
// datapath mux selects and the multicycle FSM state set.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    function automatic logic op_known(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_BRANCH);
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic sign);
        case (f3)
            F3_BEQ:  return zero;
            F3_BNE:  return ~zero;
            F3_BLT:  return sign;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus funct fields to the ALUControl code.
// Shared between the single-cycle and multicycle control units.
module rv_alu_decoder
    import rv_ctrl_pkg::*;
(
    input  aluop_t     i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7,
    input  logic       i_op5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // I-type has no subtract: funct7 is immediate bits there
                    3'b000:  o_alu_control = (i_op5 && i_funct7) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_alu_control = ALU_SLL;
                    3'b100:  o_alu_control = ALU_XOR;
                    3'b101:  o_alu_control = ALU_SRL;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main FSM controller of the multicycle RV32 core: sequences the shared
// datapath through fetch/decode/execute/memory/writeback with a memory handshake.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter logic [3:0] RST_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] OP,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    input  logic       sign,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       retire,
    output logic [3:0] state
);

    state_t r_state;
    aluop_t w_alu_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= state_t'(RST_STATE);
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (OP)
                        OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                        OP_RTYPE:          r_state <= S_EXEC_R;
                        OP_ITYPE:          r_state <= S_EXEC_I;
                        OP_BRANCH:         r_state <= S_BRANCH;
                        default:           r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   r_state <= (OP == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXEC_R,
                S_EXEC_I:   r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ImmSrc    = IMM_I;
        RegWrite  = 1'b0;
        retire    = 1'b0;
        w_alu_op  = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                MemRead   = 1'b1;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_DECODE: begin
                // Branch target OldPC+immB is precomputed into ALUOut here
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                retire  = ~op_known(OP);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (OP == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                retire    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_ready;
            end
            S_EXEC_R: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_RS2;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_RS2;
                w_alu_op = ALUOP_SUB;
                PCWrite  = branch_taken(funct3, zero, sign);
                retire   = 1'b1;
            end
            default: ;
        endcase
        // Enables are masked while reset is held so an aborted access cannot write
        if (rst) begin
            PCWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            retire   = 1'b0;
        end
    end

    rv_alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7      (funct7),
        .i_op5         (OP[5]),
        .o_alu_control (ALUControl)
    );

    assign state = r_state;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: per-instruction expected traces built from the
// instruction-class rules, compared every cycle, plus literal spot checks.
module tb_rv_multicycle_ctrl;
    import rv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] OP;
    logic [2:0] funct3;
    logic       funct7, zero, sign, mem_ready;
    logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, retire;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    rv_multicycle_ctrl #(.RST_STATE(4'd0)) dut (
        .clk(clk), .rst(rst), .OP(OP), .funct3(funct3), .funct7(funct7),
        .zero(zero), .sign(sign), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
        .retire(retire), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mrd, mwr, irw;
        logic [1:0] res, sa, sb, imm;
        logic       rw;
        logic [2:0] alu;
        logic       ret;
    } obs_t;

    obs_t w_dut;
    assign w_dut = {state, PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUControl, retire};

    int    n_tests = 0;
    int    n_fail  = 0;
    obs_t  r_exp;
    bit    exp_valid = 1'b0;
    string exp_tag = "";
    obs_t  trace[$];
    int    budget = -1;

    always @(negedge clk) begin
        if (exp_valid) begin
            n_tests++;
            if (w_dut !== r_exp)begin
                n_fail++;
                $display("FAIL model[%0s] t=%0t got %h (state %0d) expected %h (state %0d)",
                         exp_tag, $time, w_dut, w_dut.st, r_exp, r_exp.st);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %0s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_alu(input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7);
        case (f3)
            3'd0:    return (op[5] && f7) ? 3'b010 : 3'b000;
            3'd1:    return 3'b001;
            3'd4:    return 3'b100;
            3'd5:    return 3'b101;
            3'd6:    return 3'b110;
            3'd7:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic exp_taken(input logic [2:0] f3, input logic z, input logic s);
        if (f3 == 3'd0) return z;
        if (f3 == 3'd1) return !z;
        if (f3 == 3'd4) return s;
        return 1'b0;
    endfunction

    function automatic obs_t blank(input state_t st);
        obs_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    // One clock of the expected trace; silently skipped once the budget is spent.
    task automatic step(input obs_t e, input logic mr, input logic z, input logic s,
                        input string tg);
        if (budget == 0) return;
        if (budget > 0) budget--;
        mem_ready = mr; zero = z; sign = s;
        r_exp = e; exp_tag = tg; exp_valid = 1'b1;
        @(negedge clk);
        trace.push_back(w_dut);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int fst, input int mst, input logic zb, input logic sb);
        obs_t e;
        OP = op; funct3 = f3; funct7 = f7;
        trace.delete();
        for (int k = 0; k <= fst; k++) begin
            e = blank(S_FETCH);
            e.mrd = 1'b1; e.sb = 2'b10; e.res = 2'b10;
            e.irw = (k == fst); e.pcw = (k == fst);
            step(e, k == fst, rb(), rb(), "fetch");
        end
        e = blank(S_DECODE);
        e.sa = 2'b01; e.sb = 2'b01; e.imm = 2'b10;
        e.ret = !(op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH});
        step(e, rb(), rb(), rb(), "decode");
        if (op == OP_LOAD || op == OP_STORE) begin
            e = blank(S_MEMADR);
            e.sa = 2'b10; e.sb = 2'b01; e.imm = (op == OP_STORE) ? 2'b01 : 2'b00;
            step(e, rb(), rb(), rb(), "memadr");
            for (int k = 0; k <= mst; k++) begin
                e = blank(op == OP_STORE ? S_MEMWRITE : S_MEMREAD);
                e.adr = 1'b1;
                if (op == OP_STORE) begin
                    e.mwr = 1'b1; e.ret = (k == mst);
                end else begin
                    e.mrd = 1'b1;
                end
                step(e, k == mst, rb(), rb(), op == OP_STORE ? "memwrite" : "memread");
            end
            if (op == OP_LOAD) begin
                e = blank(S_MEMWB);
                e.res = 2'b01; e.rw = 1'b1; e.ret = 1'b1;
                step(e, rb(), rb(), rb(), "memwb");
            end
        end else if (op == OP_RTYPE || op == OP_ITYPE) begin
            e = blank(op == OP_RTYPE ? S_EXEC_R : S_EXEC_I);
            e.sa = 2'b10; e.sb = (op == OP_RTYPE) ? 2'b00 : 2'b01;
            e.alu = exp_alu(op, f3, f7);
            step(e, rb(), rb(), rb(), "exec");
            e = blank(S_ALUWB);
            e.rw = 1'b1; e.ret = 1'b1;
            step(e, rb(), rb(), rb(), "aluwb");
        end else if (op == OP_BRANCH) begin
            e = blank(S_BRANCH);
            e.sa = 2'b10; e.alu = 3'b010; e.pcw = exp_taken(f3, zb, sb); e.ret = 1'b1;
            step(e, rb(), zb, sb, "branch");
        end
    endtask

    function automatic int count_ret();
        int n = 0;
        foreach (trace[i]) n += int'(trace[i].ret);
        return n;
    endfunction

    initial begin
        obs_t e;
        logic [6:0] op;
        int cnt, total_ret;

        rst = 1'b1; mem_ready = 1'b0; OP = '0; funct3 = '0; funct7 = 1'b0;
        zero = 1'b0; sign = 1'b0;
        #2;
        e = blank(S_FETCH); e.sb = 2'b10; e.res = 2'b10;
        check("reset_vector", 32'(w_dut), 32'(e));
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // lw, no stalls
        run_instr(OP_LOAD, 3'd2, 1'b0, 0, 0, 1'b0, 1'b0);
        check("lw_cycles", trace.size(), 5);
        check("lw_state2", trace[2].st, 4'(S_MEMADR));
        check("lw_state3", trace[3].st, 4'(S_MEMREAD));
        check("lw_state4", trace[4].st, 4'(S_MEMWB));
        check("lw_regwrite_c5", trace[4].rw, 1);
        check("lw_resultsrc_c5", trace[4].res, 2'b01);
        check("lw_retire_once", count_ret(), 1);

        // sw with three stalled MEMWRITE cycles
        run_instr(OP_STORE, 3'd2, 1'b0, 0, 3, 1'b0, 1'b0);
        check("sw_cycles", trace.size(), 7);
        cnt = 0;
        foreach (trace[i]) cnt += int'(trace[i].mwr && trace[i].adr);
        check("sw_memwrite_cycles", cnt, 4);
        check("sw_retire_last", trace[6].ret, 1);
        check("sw_retire_once", count_ret(), 1);

        run_instr(OP_RTYPE, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0);
        check("rtype_sub_alu", trace[2].alu, 3'b010);
        run_instr(OP_ITYPE, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0);
        check("itype_add_alu", trace[2].alu, 3'b000);

        run_instr(OP_BRANCH, 3'd0, 1'b0, 0, 0, 1'b1, 1'b0);
        check("beq_taken", trace[2].pcw, 1);
        check("br_cycles", trace.size(), 3);
        run_instr(OP_BRANCH, 3'd1, 1'b0, 0, 0, 1'b1, 1'b0);
        check("bne_not_taken", trace[2].pcw, 0);
        run_instr(OP_BRANCH, 3'd4, 1'b0, 0, 0, 1'b0, 1'b1);
        check("blt_taken", trace[2].pcw, 1);
        run_instr(OP_BRANCH, 3'd7, 1'b0, 0, 0, 1'b1, 1'b1);
        check("f3_111_not_taken", trace[2].pcw, 0);

        run_instr(7'b1111111, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0);
        check("nop_cycles", trace.size(), 2);
        check("nop_retire", trace[1].ret, 1);
        cnt = 0;
        foreach (trace[i]) cnt += int'(trace[i].rw || trace[i].mwr);
        check("nop_no_writes", cnt, 0);

        // Asynchronous reset in EXEC_R
        budget = 2;
        run_instr(OP_RTYPE, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0);
        exp_valid = 1'b0; mem_ready = 1'b0;
        check("pre_rst_exec_r", state, 4'(S_EXEC_R));
        rst = 1'b1; #1;
        check("rst_state", state, 4'd0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_memread", MemRead, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; #1;
        check("post_rst_memread", MemRead, 1);
        @(posedge clk); #1;

        // Asynchronous reset in MEMWB kills the pending register write
        budget = 4;
        run_instr(OP_LOAD, 3'd2, 1'b0, 0, 0, 1'b0, 1'b0);
        exp_valid = 1'b0; mem_ready = 1'b0;
        check("pre_rst_memwb_regwrite", RegWrite, 1);
        rst = 1'b1; #1;
        check("rst_memwb_regwrite", RegWrite, 0);
        check("rst_memwb_retire", retire, 0);
        check("rst_memwb_state", state, 4'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        budget = -1;

        total_ret = 0;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(5))
                0: op = OP_LOAD;
                1: op = OP_STORE;
                2: op = OP_RTYPE;
                3: op = OP_ITYPE;
                4: op = OP_BRANCH;
                default: begin
                    do op = 7'($urandom_range(127));
                    while (op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH});
                end
            endcase
            run_instr(op, 3'($urandom_range(7)), rb(), int'($urandom_range(2)),
                      int'($urandom_range(2)), rb(), rb());
            total_ret += count_ret();
        end
        check("random_retire_total", total_ret, 150);

        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Main FSM controller for the multicycle RV32 variant of the core.
- Sequences the shared datapath (one memory port for instruction and data, one ALU, ALUOut/Data/IR registers) through fetch, decode, execute, memory and writeback steps.
- Uses the same opcode/funct decode and ALUControl encoding as the single-cycle control unit.
- Adds a memory-ready handshake and a per-instruction retire pulse.

Parameters:
- RST_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- clk        in   1  core clock, rising edge
- rst        in   1  reset; one clock; asynchronous, active-high
- OP         in   7  instr[6:0] from the instruction register
- funct3     in   3  instr[14:12]
- funct7     in   1  instr[30]
- zero       in   1  ALU result == 0
- sign       in   1  ALU result[31]
- mem_ready  in   1  memory completes the current access this cycle
- PCWrite    out  1  load PC
- AdrSrc     out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead    out  1  memory read request
- MemWrite   out  1  memory write request
- IRWrite    out  1  load IR and OldPC
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALU result
- ALUSrcA    out  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB    out  2  00 rs2, 01 imm, 10 const 4
- ImmSrc     out  2  00 I, 01 S, 10 B
- RegWrite   out  1  register file write
- ALUControl out  3  000 add, 010 sub, 001 sll, 100 xor, 101 srl, 110 or, 111 and
- retire     out  1  one-cycle pulse when an instruction completes
- state      out  4  current state, for debug

Behaviour:
- Outputs are combinational from the state register and the instruction fields. All enables are 0 in any state that does not assert them.
- Reset: state = FETCH. With mem_ready = 0 during reset, all outputs are 0, except that the FETCH-state values of AdrSrc, ALUSrcA, ALUSrcB and ResultSrc are present.
- FETCH:
  - Drives AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10.
  - IRWrite and PCWrite equal mem_ready.
  - Holds in FETCH while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add; this precomputes the branch target into ALUOut.
  - Next state by OP:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - any other OP -> FETCH with retire=1 (treated as a NOP).
- MEMADR:
  - Drives ALUSrcA=10, ALUSrcB=01, add.
  - ImmSrc=00 for loads, 01 for stores.
  - Goes to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: AdrSrc=1, MemRead=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1, then goes to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. Holds until mem_ready=1, then goes to FETCH with retire=1 in that same cycle.
- EXEC_R / EXEC_I:
  - ALUSrcA=10. ALUSrcB=00 for EXEC_R, 01 for EXEC_I (ImmSrc=00).
  - funct3 decode: 000 gives sub only when OP[5]=1 and funct7=1, otherwise add; 001 sll; 100 xor; 101 srl; 110 or; 111 and; other values give add.
  - Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1, then goes to FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = taken, where taken is: funct3 000 -> zero; 001 -> ~zero; 100 -> sign; any other funct3 -> 0.
  - retire=1, then goes to FETCH.
- Latency with mem_ready held at 1: load 5 cycles; store, R-type and I-type 4 cycles; branch 3 cycles; unknown opcode 2 cycles. Each extra mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Asynchronous reset mid-instruction aborts immediately: state becomes FETCH and no write enables are asserted after rst rises.
- Unreachable state encodings go to FETCH with all enables 0.
- mem_ready is ignored in states that do not access memory.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH)
  - ALUControl codes
  - ImmSrc codes
  - the state enum
- One sub-module, rv_alu_decoder, maps (ALUOp, funct3, funct7, OP[5]) to ALUControl. It is combinational and reusable by the single-cycle core.

Test Plan:
- Reset mid-EXEC_R: rst pulse -> state=0 (FETCH), RegWrite=0 and MemWrite=0 asynchronously, MemRead=1 once rst is released.
- lw (OP=0000011) with mem_ready=1 -> state sequence 0,1,MEMADR,MEMREAD,MEMWB; RegWrite=1 and ResultSrc=01 in cycle 5; retire=1 exactly once.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, AdrSrc=1, retire on the mem_ready cycle, total 7 cycles.
- R-type sub (OP=0110011, funct3=000, funct7=1) -> ALUControl=010 in EXEC_R. Same fields with OP=0010011 -> ALUControl=000.
- Branch: beq with zero=1 -> PCWrite=1 in BRANCH. bne with zero=1 -> PCWrite=0. blt with sign=1 -> PCWrite=1. funct3=111 -> PCWrite=0.
- Unknown OP=1111111 -> DECODE returns to FETCH, retire=1, no RegWrite or MemWrite asserted.
